aes_shiftmix_stage: RTL
=======================

# aes_shiftmix_stage

Registered ShiftRows + MixColumns stage of the AES encryption datapath. It consumes the 128-bit SubBytes result of the current round and produces the state that AddRoundKey consumes. The final round bypasses MixColumns. It sits between the S-box layer and the round-key XOR. A valid/ready handshake on both sides lets the iterative round controller stall it.

## Interface
- `TAG_W`, default 4 — width of the sideband tag (round number or stream ID) carried alongside the data.

- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst` in 1 — reset; synchronous, active-high.
- `in_valid` in 1 — the SubBytes output on `in_data` is valid.
- `in_ready` out 1 — the stage accepts `in_data` this cycle.
- `in_data` in 128 — SubBytes state, column-major: [127:120]=s(0,0), [119:112]=s(1,0), …, [7:0]=s(3,3).
- `in_last` in 1 — final round; skip MixColumns.
- `in_tag` in TAG_W — sideband, passed through unchanged.
- `out_valid` out 1 — `out_data` holds a transformed state.
- `out_ready` in 1 — the downstream stage takes `out_data` this cycle.
- `out_data` out 128 — transformed state, same byte ordering as `in_data`.
- `out_last` out 1 — `in_last` of the same beat.
- `out_tag` out TAG_W — `in_tag` of the same beat.

## Operation
- **Handshake**
  - An input beat transfers when `in_valid && in_ready`.
  - An output beat transfers when `out_valid && out_ready`.
- **ShiftRows**
  - Row r (byte r of each column) rotates left by r columns: s'(r,c) = s(r,(c+r) mod 4).
- **MixColumns**
  - Each column is multiplied by the fixed matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] over GF(2^8).
  - Reduction polynomial 0x11B.
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - All arithmetic is 8-bit XOR/xtime; no carries.
- **Last-round bypass**
  - When `in_last`=1, the output is ShiftRows only.
  - `out_last` and `out_tag` stay aligned with their data beat.
- **Transform placement**
  - The transform is combinational on `in_data`. The result is captured into the output register on acceptance.
- **Register states**
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
  - SKID: FULL plus one buffered beat. Exists only when the macro is defined.
- **Transitions without the skid buffer**
  - EMPTY→FULL on an input transfer.
  - FULL→FULL when an input and an output transfer occur in the same cycle; the register reloads.
  - FULL→EMPTY on an output transfer with no input transfer.
- **Ordering**
  - Beats leave in acceptance order. No beat is dropped or duplicated.
- **Reset**
  - Reset mid-operation discards all held beats, including the skid entry.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_tag`=0.
  - `in_ready`=0 while `rst`=1.

## Timing
- **Latency**
  - Exactly 1 cycle: a beat accepted at edge N has `out_valid`=1 and its transformed data after edge N.
- **Throughput**
  - 1 beat/cycle while `out_ready`=1.
- **Output stability**
  - `out_data`, `out_last`, `out_tag` remain stable while `out_valid && !out_ready`.
- **`in_ready` without the skid buffer**
  - `in_ready` = !rst && (!out_valid || out_ready).
  - This is a combinational path from `out_ready`.
- **Full, stalled**
  - `out_valid`=1 and `out_ready`=0 → `in_ready`=0.
  - The input is held off and no state changes.
- **Empty**
  - `out_valid`=0 → `in_ready`=1 regardless of `out_ready`.
- **Reset release**
  - First cycle after `rst` deasserts: `in_ready`=1.

## Configuration
- Macro: `AES_SHIFTMIX_SKID_EN`.
- **Defined**
  - A second 128+1+TAG_W-bit skid register is added.
  - `in_ready` is a register output, with no combinational path from `out_ready`.
  - `in_ready` = !skid_valid after reset.
  - When an input arrives while FULL and `out_ready`=0, the beat goes to the skid register (FULL→SKID) and `in_ready` drops on the next cycle.
  - On the next output transfer, the skid beat moves to the output register (SKID→FULL) and `in_ready` returns to 1.
  - Latency for an unstalled beat stays 1 cycle.
- **Undefined**
  - Single output register only, with the combinational `in_ready` defined above.
  - No skid state exists.

## Test plan
- **Single beat, MixColumns applied**
  - Apply `in_data`=d42711aee0bf98f1b8b45de51e415230, `in_last`=0, `in_tag`=1.
  - One cycle later: `out_data`=046681e5e0cb199a48f8d37a2806264c, `out_tag`=1.
- **Single beat, last-round bypass**
  - Apply the same data with `in_last`=1.
  - Required: `out_data`=d4bf5d30e0b452aeb84111f11e2798e5, `out_last`=1.
- **Back-to-back stream**
  - Apply 8 consecutive beats (tags 0–7) with `out_ready`=1 throughout.
  - Required: 8 output beats on consecutive cycles, tags 0–7 in order, each data value matching the reference model.
- **Backpressure**
  - Hold `out_ready`=0 for 5 cycles with `in_valid`=1.
  - Without the macro: exactly 1 beat is held, `in_ready`=0, and the held beat is stable.
  - With the macro: exactly 2 beats are held.
  - Releasing `out_ready` delivers the beats in order with no loss.
- **Reset mid-stream**
  - Assert `rst` for 1 cycle while FULL (and while SKID with the macro).
  - Required: `out_valid`=0, `out_data`=0, `out_tag`=0, `in_ready`=0 during reset and `in_ready`=1 the next cycle.
  - No stale beat is emitted afterwards.

Source files
------------

// File: rtl/aes_shiftmix_stage.sv
// AES ShiftRows + MixColumns pipeline stage with valid/ready on both sides.
// Define AES_SHIFTMIX_SKID_EN to add a skid register and a registered in_ready.
module aes_shiftmix_stage #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NCOL   = 4;
    localparam int unsigned COL_W  = BYTE_W * NCOL;
    localparam int unsigned PAY_W  = DATA_W + 1 + TAG_W;

    // Bit 0 doubles as out_valid; bit 1 marks an occupied skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              in_fire;
    logic              out_fire;
    logic              load_out;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] xform;
    logic [PAY_W-1:0]  payload_in;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // s'(r,c) = s(r,(c+r) mod 4); byte (r,c) sits at index 4c+r from the MSB.
    function automatic logic [DATA_W-1:0] shift_rows(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] o;
        o = '0;
        for (int unsigned c = 0; c < NCOL; c++) begin
            for (int unsigned r = 0; r < NCOL; r++) begin
                o[DATA_W-1-BYTE_W*(NCOL*c+r) -: BYTE_W] =
                    s[DATA_W-1-BYTE_W*(NCOL*((c+r)%NCOL)+r) -: BYTE_W];
            end
        end
        return o;
    endfunction

    function automatic logic [DATA_W-1:0] mix_columns(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] o;
        logic [BYTE_W-1:0] a0, a1, a2, a3;
        logic [BYTE_W-1:0] b0, b1, b2, b3;
        o = '0;
        for (int unsigned c = 0; c < NCOL; c++) begin
            a0 = s[DATA_W-1-COL_W*c -: BYTE_W];
            a1 = s[DATA_W-1-COL_W*c-BYTE_W -: BYTE_W];
            a2 = s[DATA_W-1-COL_W*c-2*BYTE_W -: BYTE_W];
            a3 = s[DATA_W-1-COL_W*c-3*BYTE_W -: BYTE_W];
            b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            o[DATA_W-1-COL_W*c -: COL_W] = {b0, b1, b2, b3};
        end
        return o;
    endfunction

    // Transform is purely combinational on the incoming beat.
    always_comb begin
        shifted    = shift_rows(in_data);
        xform      = in_last ? shifted : mix_columns(shifted);
        payload_in = {xform, in_last, in_tag};
    end

    assign out_valid = state[0];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef AES_SHIFTMIX_SKID_EN
    logic             load_skid;
    logic             load_from_skid;
    logic [PAY_W-1:0] skid_q;

    // Depends only on registered state, never on out_ready.
    assign in_ready = !rst && (state != ST_SKID);
`else
    assign in_ready = !rst && (!out_valid || out_ready);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (in_fire) state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (out_fire && !in_fire) begin
                    state_nxt = ST_EMPTY;
`ifdef AES_SHIFTMIX_SKID_EN
                end else if (in_fire && !out_ready) begin
                    state_nxt = ST_SKID;
`endif
                end
            end
`ifdef AES_SHIFTMIX_SKID_EN
            ST_SKID: begin
                if (out_ready) state_nxt = ST_FULL;
            end
`endif
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        load_out = 1'b0;
`ifdef AES_SHIFTMIX_SKID_EN
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
`endif
        case (state)
            ST_EMPTY: load_out = in_fire;
            ST_FULL: begin
                load_out = in_fire && out_ready;
`ifdef AES_SHIFTMIX_SKID_EN
                load_skid = in_fire && !out_ready;
`endif
            end
`ifdef AES_SHIFTMIX_SKID_EN
            ST_SKID: load_from_skid = out_ready;
`endif
            default: load_out = 1'b0;
        endcase
    end

    // Output register: holds steady unless a reload is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            {out_data, out_last, out_tag} <= PAY_W'(0);
        end else if (load_out) begin
            {out_data, out_last, out_tag} <= payload_in;
`ifdef AES_SHIFTMIX_SKID_EN
        end else if (load_from_skid) begin
            {out_data, out_last, out_tag} <= skid_q;
`endif
        end
    end

`ifdef AES_SHIFTMIX_SKID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q <= PAY_W'(0);
        end else if (load_skid) begin
            skid_q <= payload_in;
        end
    end
`endif

endmodule
